// File: rtl/obs_ctrl.sv
// Obstacle controller: spawns one obstacle at the right screen edge and scrolls it left once per frame.
// After each pass it waits a pseudo-random gap, and the speed rises every eighth pass.
module obs_ctrl #(
   parameter int CONV       = 0,
   parameter int SPAWN_X    = 656,
   parameter int SPEED_INIT = 2,
   parameter int SPEED_MAX  = 7
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_frame_tick,
   input  logic          i_game_start,
   input  logic          i_game_over,
   output logic [9:CONV] o_xpos,
   output logic          o_active,
   output logic          o_passed,
   output logic [2:0]    o_speed
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_WAIT    = 2'd2;
   localparam logic [1:0] ST_HALT    = 2'd3;
   localparam logic [9:0] SPAWN_FULL = 10'(SPAWN_X);
   localparam logic [2:0] SPD_INIT   = 3'(SPEED_INIT);
   localparam logic [2:0] SPD_MAX    = 3'(SPEED_MAX);
   localparam logic [7:0] LFSR_SEED  = 8'hA5;

   // x^8+x^6+x^5+x^4+1; an upset into all-zero is pulled back to the seed
   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      logic [7:0] n;
      n = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
      if (n == 8'h00) begin
         return LFSR_SEED;
      end else begin
         return n;
      end
   endfunction

   logic          live_q;
   logic [1:0]    state_q, state_d;
   logic [9:CONV] x_q, x_d;
   logic          active_q, active_d;
   logic          passed_q, passed_d;
   logic [2:0]    speed_q, speed_d;
   logic [2:0]    pass_cnt_q, pass_cnt_d;
   logic [6:0]    gap_q, gap_d;
   logic [7:0]    lfsr_q, lfsr_d;
   logic [9:0]    x_full_s;
   logic [9:0]    x_sub_s;

   // next-state logic for the obstacle FSM, pass counter, gap timer and LFSR
   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      speed_d    = speed_q;
      pass_cnt_d = pass_cnt_q;
      gap_d      = gap_q;
      passed_d   = 1'b0;
      lfsr_d     = lfsr_next(lfsr_q);
      x_full_s   = 10'(x_q) << CONV;
      x_sub_s    = x_full_s - {7'd0, speed_q};
      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (i_game_start) begin
               state_d    = ST_RUN;
               x_d        = SPAWN_FULL[9:CONV];
               speed_d    = SPD_INIT;
               pass_cnt_d = 3'd0;
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (i_game_over) begin
               state_d = ST_HALT;
            end else if (!i_frame_tick) begin
               state_d = ST_RUN;
            end else if (x_full_s > {7'd0, speed_q}) begin
               x_d = x_sub_s[9:CONV];
            end else begin
               state_d    = ST_WAIT;
               passed_d   = 1'b1;
               pass_cnt_d = pass_cnt_q + 3'd1;
               gap_d      = 7'd16 + {1'b0, lfsr_q[5:0]};
               if (pass_cnt_q == 3'd7 && speed_q < SPD_MAX) begin
                  speed_d = speed_q + 3'd1;
               end else begin
                  speed_d = speed_q;
               end
            end
         end
         ST_WAIT: begin
            if (i_game_over) begin
               state_d = ST_HALT;
            end else if (!i_frame_tick) begin
               state_d = ST_WAIT;
            end else if (gap_q <= 7'd1) begin
               state_d = ST_RUN;
               x_d     = SPAWN_FULL[9:CONV];
            end else begin
               gap_d = gap_q - 7'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      active_d = (state_d == ST_RUN) || (state_d == ST_HALT);
   end

   // state registers; the first edge after reset release only arms live_q
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q     <= 1'b0;
         state_q    <= ST_IDLE;
         x_q        <= SPAWN_FULL[9:CONV];
         active_q   <= 1'b0;
         passed_q   <= 1'b0;
         speed_q    <= SPD_INIT;
         pass_cnt_q <= 3'd0;
         gap_q      <= 7'd0;
         lfsr_q     <= LFSR_SEED;
      end else if (!live_q) begin
         live_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         active_q   <= active_d;
         passed_q   <= passed_d;
         speed_q    <= speed_d;
         pass_cnt_q <= pass_cnt_d;
         gap_q      <= gap_d;
         lfsr_q     <= lfsr_d;
      end
   end

   assign o_xpos   = x_q;
   assign o_active = active_q;
   assign o_passed = passed_q;
   assign o_speed  = speed_q;

endmodule

// File: tb/tb_obs_ctrl.sv
// Randomised and directed bench for obs_ctrl against a frame-level behavioural model.
module tb_obs_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick, start, over;
   logic [9:0] xpos;
   logic       active, passed;
   logic [2:0] speed;

   always #5 clk = ~clk;

   obs_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_frame_tick (tick),
      .i_game_start (start),
      .i_game_over  (over),
      .o_xpos       (xpos),
      .o_active     (active),
      .o_passed     (passed),
      .o_speed      (speed)
   );

   int total = 0;
   int bad   = 0;

   // model: mode 0 idle, 1 scrolling, 2 gap, 3 halted
   int m_mode, m_x, m_speed, m_passes, m_gap, m_lfsr, m_passed, m_live;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic m_reset();
      m_mode = 0; m_x = 656; m_speed = 2; m_passes = 0;
      m_gap = 0; m_lfsr = 8'hA5; m_passed = 0; m_live = 0;
   endtask

   task automatic m_step(input int t, input int s, input int g);
      int cur;
      int fb;
      if (m_live == 0) begin
         m_live = 1;
         return;
      end
      cur = m_lfsr;
      fb = ((cur >> 7) ^ (cur >> 5) ^ (cur >> 4) ^ (cur >> 3)) & 1;
      m_lfsr = ((cur << 1) | fb) & 255;
      m_passed = 0;
      if ((m_mode == 0 || m_mode == 3) && s != 0) begin
         m_mode = 1; m_x = 656; m_speed = 2; m_passes = 0;
      end else if ((m_mode == 1 || m_mode == 2) && g != 0) begin
         m_mode = 3;
      end else if (m_mode == 1 && t != 0) begin
         if (m_x > m_speed) begin
            m_x = m_x - m_speed;
         end else begin
            m_passed = 1;
            m_passes++;
            if (m_passes % 8 == 0 && m_speed < 7) m_speed++;
            m_gap = 16 + (cur % 64);
            m_mode = 2;
         end
      end else if (m_mode == 2 && t != 0) begin
         if (m_gap == 1) begin
            m_mode = 1;
            m_x = 656;
         end else begin
            m_gap--;
         end
      end
   endtask

   task automatic compare_all();
      chk("xpos",   int'(xpos),   m_x);
      chk("active", int'(active), (m_mode == 1 || m_mode == 3) ? 1 : 0);
      chk("passed", int'(passed), m_passed);
      chk("speed",  int'(speed),  m_speed);
   endtask

   task automatic cyc(input int t, input int s, input int g);
      tick = (t != 0); start = (s != 0); over = (g != 0);
      m_step(t, s, g);
      @(negedge clk);
      compare_all();
   endtask

   task automatic async_reset_check(input string tag);
      #2 rst_n = 1'b0;
      #1;
      chk({tag, "_rst_xpos"},   int'(xpos),       656);
      chk({tag, "_rst_active"}, int'(active),     0);
      chk({tag, "_rst_passed"}, int'(passed),     0);
      chk({tag, "_rst_speed"},  int'(speed),      2);
      chk({tag, "_rst_lfsr"},   int'(dut.lfsr_q), 8'hA5);
      m_reset();
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;
      cyc(0, 0, 0);
   endtask

   initial begin
      int n, g0, guard;
      rst_n = 1'b0; tick = 1'b0; start = 1'b0; over = 1'b0;
      m_reset();
      repeat (3) @(negedge clk);
      chk("reset_xpos",   int'(xpos),   656);
      chk("reset_active", int'(active), 0);
      chk("reset_speed",  int'(speed),  2);
      compare_all();
      rst_n = 1'b1;
      cyc(0, 0, 0);
      cyc(0, 0, 1);

      // start then three frames
      cyc(0, 1, 0);
      chk("start_xpos", int'(xpos), 656);
      cyc(1, 0, 0); chk("tick1_xpos", int'(xpos), 654);
      cyc(1, 0, 0); chk("tick2_xpos", int'(xpos), 652);
      cyc(1, 0, 0); chk("tick3_xpos", int'(xpos), 650);
      chk("run_active", int'(active), 1);
      chk("run_speed",  int'(speed),  2);

      // game over together with a tick at x=300
      guard = 0;
      while (m_x != 300 && guard < 400) begin cyc(1, 0, 0); guard++; end
      chk("reach_300", m_x, 300);
      cyc(1, 0, 1);
      chk("halt_xpos", int'(xpos), 300);
      chk("halt_active", int'(active), 1);
      repeat (5) cyc(1, 0, 0);
      chk("halt_frozen_xpos", int'(xpos), 300);
      cyc(0, 1, 1);
      chk("restart_xpos",  int'(xpos),  656);
      chk("restart_speed", int'(speed), 2);

      // first pass and the following gap
      guard = 0;
      while (m_passed == 0 && guard < 1000) begin cyc(1, 0, 0); guard++; end
      chk("pass_pulse",  int'(passed), 1);
      chk("pass_active", int'(active), 0);
      chk("gap_range",   (m_gap >= 16 && m_gap <= 79) ? 1 : 0, 1);
      g0 = m_gap;
      n = 0;
      while (m_mode != 1 && n < 100) begin cyc(1, 0, 0); n++; end
      chk("gap_ticks", n, g0);
      chk("respawn_xpos",   int'(xpos),   656);
      chk("respawn_active", int'(active), 1);

      // speed ramp over many passes
      guard = 0;
      while (m_passes < 56 && guard < 40000) begin
         cyc(1, 0, 0);
         guard++;
         if (m_passed != 0 && m_passes == 8) chk("speed_after_8", int'(speed), 3);
      end
      chk("speed_after_56", int'(speed), 7);
      guard = 0;
      while (m_passes < 64 && guard < 10000) begin cyc(1, 0, 0); guard++; end
      chk("speed_saturated", int'(speed), 7);

      // asynchronous reset mid-WAIT, then mid-RUN
      guard = 0;
      while (m_mode != 2 && guard < 2000) begin cyc(1, 0, 0); guard++; end
      chk("in_wait", m_mode, 2);
      async_reset_check("wait");
      cyc(1, 0, 1);
      cyc(1, 0, 0);
      cyc(0, 1, 0);
      repeat (30) cyc(1, 0, 0);
      async_reset_check("run");

      // random traffic
      for (int i = 0; i < 5000; i++) begin
         cyc(($urandom_range(0, 99) < 60) ? 1 : 0,
             ($urandom_range(0, 149) == 0) ? 1 : 0,
             ($urandom_range(0, 299) == 0) ? 1 : 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
